// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use / MDU / branch hazard controller with saturating event counters
module hazard_ctrl #(
    parameter int AW      = 5,
    parameter int MEM_LAT = 1,
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ex_memread_i,
    input  logic [AW-1:0]    ex_rt_i,
    input  logic [AW-1:0]    id_rs_i,
    input  logic [AW-1:0]    id_rt_i,
    input  logic             id_uses_rt_i,
    input  logic             branch_taken_i,
    input  logic             mdu_start_i,
    input  logic             clr_cnt_i,
    output logic             pc_stall_o,
    output logic             if_id_stall_o,
    output logic             id_ex_stall_o,
    output logic             if_flush_o,
    output logic             id_flush_o,
    output logic             ex_flush_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int MAX_LAT = (MEM_LAT > MDU_LAT) ? MEM_LAT : MDU_LAT;
    localparam int REM_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    // rem counts the cycles still to go after the current one, minus one,
    // so the entry cycle in IDLE plus (rem+1) busy cycles equals the latency.
    localparam logic [REM_W-1:0] LOAD_INIT = REM_W'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);
    localparam logic [REM_W-1:0] MDU_INIT  = REM_W'((MDU_LAT > 1) ? MDU_LAT - 2 : 0);
    localparam logic             LOAD_LONG = (MEM_LAT > 1);
    localparam logic             MDU_LONG  = (MDU_LAT > 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_WAIT = 2'd1,
        MDU_BUSY  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [REM_W-1:0] rem;
    logic [REM_W-1:0] rem_nxt;
    logic             load_use_hit;
    logic             flush_evt;

    assign load_use_hit = ex_memread_i && (ex_rt_i != '0) &&
                          ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));

    // State and remaining-cycle register; reset aborts any stall in progress.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            rem   <= '0;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
        end
    end

    // Next state and combinational pipeline controls; everything is forced low during reset.
    always_comb begin
        state_nxt     = state;
        rem_nxt       = rem;
        pc_stall_o    = 1'b0;
        if_id_stall_o = 1'b0;
        id_ex_stall_o = 1'b0;
        if_flush_o    = 1'b0;
        id_flush_o    = 1'b0;
        ex_flush_o    = 1'b0;
        flush_evt     = 1'b0;
        if (!rst_i) begin
            if (branch_taken_i) begin
                // A taken branch wins everywhere and always lands back in IDLE.
                if_flush_o = 1'b1;
                id_flush_o = 1'b1;
                ex_flush_o = 1'b1;
                flush_evt  = 1'b1;
                state_nxt  = IDLE;
                rem_nxt    = '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (mdu_start_i) begin
                            pc_stall_o    = 1'b1;
                            if_id_stall_o = 1'b1;
                            id_ex_stall_o = 1'b1;
                            ex_flush_o    = 1'b1;
                            if (MDU_LONG) begin
                                state_nxt = MDU_BUSY;
                                rem_nxt   = MDU_INIT;
                            end
                        end else if (load_use_hit) begin
                            pc_stall_o    = 1'b1;
                            if_id_stall_o = 1'b1;
                            id_flush_o    = 1'b1;
                            if (LOAD_LONG) begin
                                state_nxt = LOAD_WAIT;
                                rem_nxt   = LOAD_INIT;
                            end
                        end
                    end
                    LOAD_WAIT: begin
                        pc_stall_o    = 1'b1;
                        if_id_stall_o = 1'b1;
                        id_flush_o    = 1'b1;
                        if (rem == '0) begin
                            state_nxt = IDLE;
                        end else begin
                            rem_nxt = rem - 1'b1;
                        end
                    end
                    MDU_BUSY: begin
                        pc_stall_o    = 1'b1;
                        if_id_stall_o = 1'b1;
                        id_ex_stall_o = 1'b1;
                        ex_flush_o    = 1'b1;
                        if (rem == '0) begin
                            state_nxt = IDLE;
                        end else begin
                            rem_nxt = rem - 1'b1;
                        end
                    end
                    default: begin
                        state_nxt = IDLE;
                        rem_nxt   = '0;
                    end
                endcase
            end
        end
    end

    // Stall-cycle counter: saturates at all-ones, clear wins over increment.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_cnt_i) begin
            stall_cnt_o <= '0;
        end else if (pc_stall_o && (stall_cnt_o != '1)) begin
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
        end
    end

    // Branch-flush event counter: saturates at all-ones, clear wins over increment.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_cnt_i) begin
            flush_cnt_o <= '0;
        end else if (flush_evt && (flush_cnt_o != '1)) begin
            flush_cnt_o <= flush_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - randomized and directed bench for hazard_ctrl against a cycle model
module tb_hazard_ctrl;

    localparam logic [5:0] C_LOAD = 6'b110010;
    localparam logic [5:0] C_MDU  = 6'b111001;
    localparam logic [5:0] C_BR   = 6'b000111;
    localparam logic [5:0] C_NONE = 6'b000000;

    logic       clk = 1'b0;
    logic       rst;
    logic       ex_memread;
    logic [4:0] ex_rt;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic       branch_taken;
    logic       mdu_start;
    logic       clr_cnt;

    logic        a_pc_stall, a_if_id_stall, a_id_ex_stall, a_if_flush, a_id_flush, a_ex_flush;
    logic [3:0]  a_stall_cnt, a_flush_cnt;
    logic        b_pc_stall, b_if_id_stall, b_id_ex_stall, b_if_flush, b_id_flush, b_ex_flush;
    logic [15:0] b_stall_cnt, b_flush_cnt;

    int total = 0;
    int bad   = 0;

    int mem_lat_p [2] = '{3, 1};
    int mdu_lat_p [2] = '{4, 1};
    int cnt_max_p [2] = '{15, 65535};

    int m_mode  [2];
    int m_left  [2];
    int m_stall [2];
    int m_flush [2];

    logic [5:0]  act_ctrl  [2];
    logic [15:0] act_stall [2];
    logic [15:0] act_flush [2];
    logic [5:0]  exp_ctrl  [2];
    logic [15:0] exp_stall [2];
    logic [15:0] exp_flush [2];

    always #5 clk = ~clk;

    hazard_ctrl #(.AW(5), .MEM_LAT(3), .MDU_LAT(4), .CNT_W(4)) u_a (
        .clk_i(clk), .rst_i(rst), .ex_memread_i(ex_memread), .ex_rt_i(ex_rt),
        .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rt_i(id_uses_rt),
        .branch_taken_i(branch_taken), .mdu_start_i(mdu_start), .clr_cnt_i(clr_cnt),
        .pc_stall_o(a_pc_stall), .if_id_stall_o(a_if_id_stall), .id_ex_stall_o(a_id_ex_stall),
        .if_flush_o(a_if_flush), .id_flush_o(a_id_flush), .ex_flush_o(a_ex_flush),
        .stall_cnt_o(a_stall_cnt), .flush_cnt_o(a_flush_cnt)
    );

    hazard_ctrl #(.AW(5), .MEM_LAT(1), .MDU_LAT(1), .CNT_W(16)) u_b (
        .clk_i(clk), .rst_i(rst), .ex_memread_i(ex_memread), .ex_rt_i(ex_rt),
        .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rt_i(id_uses_rt),
        .branch_taken_i(branch_taken), .mdu_start_i(mdu_start), .clr_cnt_i(clr_cnt),
        .pc_stall_o(b_pc_stall), .if_id_stall_o(b_if_id_stall), .id_ex_stall_o(b_id_ex_stall),
        .if_flush_o(b_if_flush), .id_flush_o(b_id_flush), .ex_flush_o(b_ex_flush),
        .stall_cnt_o(b_stall_cnt), .flush_cnt_o(b_flush_cnt)
    );

    function automatic logic hit_now();
        return ex_memread && (ex_rt != 5'd0) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    endfunction

    function automatic logic [5:0] model_ctrl(int k);
        if (rst) return C_NONE;
        if (branch_taken) return C_BR;
        if (m_mode[k] == 1) return C_LOAD;
        if (m_mode[k] == 2) return C_MDU;
        if (mdu_start) return C_MDU;
        if (hit_now()) return C_LOAD;
        return C_NONE;
    endfunction

    task automatic model_edge(int k, logic [5:0] c);
        if (rst) begin
            m_mode[k] = 0; m_left[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
            return;
        end
        if (clr_cnt) begin
            m_stall[k] = 0; m_flush[k] = 0;
        end else begin
            if (c[5] && m_stall[k] < cnt_max_p[k]) m_stall[k]++;
            if (c == C_BR && m_flush[k] < cnt_max_p[k]) m_flush[k]++;
        end
        if (c == C_BR) begin
            m_mode[k] = 0; m_left[k] = 0;
        end else if (m_mode[k] != 0) begin
            m_left[k]--;
            if (m_left[k] == 0) m_mode[k] = 0;
        end else if (c == C_MDU) begin
            m_left[k] = mdu_lat_p[k] - 1;
            m_mode[k] = (m_left[k] > 0) ? 2 : 0;
        end else if (c == C_LOAD) begin
            m_left[k] = mem_lat_p[k] - 1;
            m_mode[k] = (m_left[k] > 0) ? 1 : 0;
        end
    endtask

    // One clock cycle: sample outputs before the edge, then advance the model.
    task automatic tick();
        logic [5:0] c [2];
        #1;
        for (int k = 0; k < 2; k++) begin
            c[k]         = model_ctrl(k);
            exp_ctrl[k]  = c[k];
            exp_stall[k] = 16'(m_stall[k]);
            exp_flush[k] = 16'(m_flush[k]);
        end
        act_ctrl[0]  = {a_pc_stall, a_if_id_stall, a_id_ex_stall, a_if_flush, a_id_flush, a_ex_flush};
        act_ctrl[1]  = {b_pc_stall, b_if_id_stall, b_id_ex_stall, b_if_flush, b_id_flush, b_ex_flush};
        act_stall[0] = 16'(a_stall_cnt);
        act_flush[0] = 16'(a_flush_cnt);
        act_stall[1] = b_stall_cnt;
        act_flush[1] = b_flush_cnt;
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_edge(k, c[k]);
        @(negedge clk);
    endtask

    task automatic set_idle();
        rst = 1'b0; clr_cnt = 1'b0; ex_memread = 1'b0; ex_rt = 5'd0; id_rs = 5'd0;
        id_rt = 5'd0; id_uses_rt = 1'b0; branch_taken = 1'b0; mdu_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
            branch_taken = 1'($urandom_range(0, 1)); mdu_start = 1'($urandom_range(0, 1));
            tick();
            total++;
            if ({act_ctrl[0], act_ctrl[1]} !== 12'd0) begin
                bad++; $display("FAIL reset_ctrl act=%b/%b exp=0", act_ctrl[0], act_ctrl[1]);
            end
        end
        set_idle();
        tick();
        total++;
        if ({act_ctrl[0], act_ctrl[1], act_stall[0], act_stall[1], act_flush[0], act_flush[1]} !== 76'd0) begin
            bad++; $display("FAIL reset_state ctrl=%b/%b stall=%0d/%0d flush=%0d/%0d exp=0",
                            act_ctrl[0], act_ctrl[1], act_stall[0], act_stall[1], act_flush[0], act_flush[1]);
        end
    endtask

    task automatic test_load_use();
        ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_rt = 5'd1;
        tick();
        total++;
        if (act_ctrl[0] !== C_LOAD || act_ctrl[1] !== C_LOAD) begin
            bad++; $display("FAIL lu_rs_first act=%b/%b exp=%b", act_ctrl[0], act_ctrl[1], C_LOAD);
        end
        set_idle();
        tick();
        total++;
        if (act_ctrl[0] !== C_LOAD || act_ctrl[1] !== C_NONE || act_stall[1] !== 16'd1) begin
            bad++; $display("FAIL lu_rs_second act=%b/%b cnt_b=%0d exp=%b/%b cnt_b=1",
                            act_ctrl[0], act_ctrl[1], act_stall[1], C_LOAD, C_NONE);
        end
        tick();
        total++;
        if (act_ctrl[0] !== C_LOAD) begin
            bad++; $display("FAIL lu_rs_third act=%b exp=%b", act_ctrl[0], C_LOAD);
        end
        tick();
        total++;
        if (act_ctrl[0] !== C_NONE || act_stall[0] !== 16'd3) begin
            bad++; $display("FAIL lu_rs_release act=%b cnt=%0d exp=%b cnt=3", act_ctrl[0], act_stall[0], C_NONE);
        end
        ex_memread = 1'b1; ex_rt = 5'd9; id_rt = 5'd9; id_rs = 5'd2; id_uses_rt = 1'b1;
        tick();
        set_idle();
        total++;
        if (act_ctrl[0] !== C_LOAD || act_ctrl[1] !== C_LOAD) begin
            bad++; $display("FAIL lu_rt act=%b/%b exp=%b", act_ctrl[0], act_ctrl[1], C_LOAD);
        end
        tick();
        tick();
        tick();
        total++;
        if (act_ctrl[0] !== C_NONE || act_stall[0] !== 16'd6 || act_stall[1] !== 16'd2) begin
            bad++; $display("FAIL lu_rt_release act=%b cnt=%0d/%0d exp=%b cnt=6/2",
                            act_ctrl[0], act_stall[0], act_stall[1], C_NONE);
        end
        ex_memread = 1'b1; ex_rt = 5'd9; id_rt = 5'd9; id_rs = 5'd2; id_uses_rt = 1'b0;
        tick();
        set_idle();
        total++;
        if ({act_ctrl[0], act_ctrl[1]} !== 12'd0) begin
            bad++; $display("FAIL lu_rt_unused act=%b/%b exp=0", act_ctrl[0], act_ctrl[1]);
        end
    endtask

    task automatic test_zero_reg();
        ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1;
        tick();
        set_idle();
        total++;
        if ({act_ctrl[0], act_ctrl[1]} !== 12'd0) begin
            bad++; $display("FAIL zero_reg act=%b/%b exp=0", act_ctrl[0], act_ctrl[1]);
        end
    endtask

    task automatic test_mdu();
        clr_cnt = 1'b1;
        tick();
        set_idle();
        mdu_start = 1'b1; ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
        tick();
        set_idle();
        total++;
        if (act_ctrl[0] !== C_MDU || act_ctrl[1] !== C_MDU) begin
            bad++; $display("FAIL mdu_start act=%b/%b exp=%b", act_ctrl[0], act_ctrl[1], C_MDU);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (act_ctrl[0] !== C_MDU || act_ctrl[1] !== C_NONE) begin
                bad++; $display("FAIL mdu_hold%0d act=%b/%b exp=%b/%b", i, act_ctrl[0], act_ctrl[1], C_MDU, C_NONE);
            end
        end
        tick();
        total++;
        if (act_ctrl[0] !== C_NONE || act_stall[0] !== 16'd4 || act_stall[1] !== 16'd1) begin
            bad++; $display("FAIL mdu_release act=%b cnt=%0d/%0d exp=%b cnt=4/1",
                            act_ctrl[0], act_stall[0], act_stall[1], C_NONE);
        end
    endtask

    task automatic test_branch();
        clr_cnt = 1'b1;
        tick();
        set_idle();
        branch_taken = 1'b1; ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
        tick();
        set_idle();
        total++;
        if (act_ctrl[0] !== C_BR || act_ctrl[1] !== C_BR) begin
            bad++; $display("FAIL br_priority act=%b/%b exp=%b", act_ctrl[0], act_ctrl[1], C_BR);
        end
        tick();
        total++;
        if (act_ctrl[0] !== C_NONE || act_flush[0] !== 16'd1 || act_flush[1] !== 16'd1 || act_stall[0] !== 16'd0) begin
            bad++; $display("FAIL br_after act=%b flush=%0d/%0d stall=%0d exp=0 flush=1/1 stall=0",
                            act_ctrl[0], act_flush[0], act_flush[1], act_stall[0]);
        end
        ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
        tick();
        set_idle();
        branch_taken = 1'b1;
        tick();
        set_idle();
        total++;
        if (act_ctrl[0] !== C_BR) begin
            bad++; $display("FAIL br_in_load act=%b exp=%b", act_ctrl[0], C_BR);
        end
        tick();
        total++;
        if (act_ctrl[0] !== C_NONE || act_flush[0] !== 16'd2) begin
            bad++; $display("FAIL br_load_exit act=%b flush=%0d exp=0 flush=2", act_ctrl[0], act_flush[0]);
        end
        mdu_start = 1'b1;
        tick();
        set_idle();
        branch_taken = 1'b1;
        tick();
        set_idle();
        tick();
        total++;
        if (act_ctrl[0] !== C_NONE || act_flush[0] !== 16'd3) begin
            bad++; $display("FAIL br_mdu_exit act=%b flush=%0d exp=0 flush=3", act_ctrl[0], act_flush[0]);
        end
    endtask

    task automatic test_reset_mid_mdu();
        mdu_start = 1'b1;
        tick();
        set_idle();
        rst = 1'b1;
        tick();
        total++;
        if ({act_ctrl[0], act_ctrl[1]} !== 12'd0) begin
            bad++; $display("FAIL rst_mid_mdu act=%b/%b exp=0", act_ctrl[0], act_ctrl[1]);
        end
        set_idle();
        tick();
        total++;
        if (act_ctrl[0] !== C_NONE || act_stall[0] !== 16'd0 || act_flush[0] !== 16'd0) begin
            bad++; $display("FAIL rst_mid_idle act=%b stall=%0d flush=%0d exp=0", act_ctrl[0], act_stall[0], act_flush[0]);
        end
    endtask

    task automatic test_saturation();
        ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
        for (int i = 0; i < 20; i++) tick();
        set_idle();
        tick();
        total++;
        if (act_stall[0] !== 16'd15 || act_stall[1] !== 16'd20) begin
            bad++; $display("FAIL sat_stall act=%0d/%0d exp=15/20", act_stall[0], act_stall[1]);
        end
        tick();
        tick();
        clr_cnt = 1'b1;
        tick();
        set_idle();
        tick();
        total++;
        if (act_stall[0] !== 16'd0 || act_stall[1] !== 16'd0) begin
            bad++; $display("FAIL clr_cnt act=%0d/%0d exp=0/0", act_stall[0], act_stall[1]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 99) == 0);
            clr_cnt      = ($urandom_range(0, 49) == 0);
            branch_taken = ($urandom_range(0, 9) == 0);
            mdu_start    = ($urandom_range(0, 11) == 0);
            ex_memread   = 1'($urandom_range(0, 1));
            ex_rt        = 5'($urandom_range(0, 3));
            id_rs        = 5'($urandom_range(0, 3));
            id_rt        = 5'($urandom_range(0, 3));
            id_uses_rt   = 1'($urandom_range(0, 1));
            tick();
            total++;
            if ({act_ctrl[0], act_ctrl[1], act_stall[0], act_stall[1], act_flush[0], act_flush[1]} !==
                {exp_ctrl[0], exp_ctrl[1], exp_stall[0], exp_stall[1], exp_flush[0], exp_flush[1]}) begin
                bad++;
                $display("FAIL random cyc=%0d ctrl=%b/%b stall=%0d/%0d flush=%0d/%0d exp ctrl=%b/%b stall=%0d/%0d flush=%0d/%0d",
                         i, act_ctrl[0], act_ctrl[1], act_stall[0], act_stall[1], act_flush[0], act_flush[1],
                         exp_ctrl[0], exp_ctrl[1], exp_stall[0], exp_stall[1], exp_flush[0], exp_flush[1]);
            end
        end
        set_idle();
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0; m_left[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
        end
        set_idle();
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_load_use();
        test_zero_reg();
        test_mdu();
        test_branch();
        test_reset_mid_mdu();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller for the 5-stage MIPS core, sitting beside the ID stage and driving the PC, IF/ID, ID/EX and EX/MEM pipeline-register controls. It detects load-use hazards and holds the front end for a configurable number of bubble cycles to match data-memory latency. It also freezes the pipeline while a multi-cycle multiply/divide unit (MDU) occupies EX, and flushes IF/ID/EX on a taken branch. Saturating stall and flush event counters are exposed for performance measurement.

## Interface

Parameters:
- AW, 5, register-address width.
- MEM_LAT, 1, load-use bubble cycles (1..8).
- MDU_LAT, 4, cycles an MDU op occupies EX (1..16).
- CNT_W, 16, width of each performance counter.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- ex_memread_i  in  1  instruction in EX is a load.
- ex_rt_i  in  AW  destination register of the EX-stage load.
- id_rs_i  in  AW  rs of the ID-stage instruction.
- id_rt_i  in  AW  rt of the ID-stage instruction.
- id_uses_rt_i  in  1  ID-stage instruction reads rt; 0 for I-type/immediate forms.
- branch_taken_i  in  1  branch resolved taken in EX this cycle.
- mdu_start_i  in  1  first EX cycle of an MDU instruction.
- clr_cnt_i  in  1  synchronous clear of both counters.
- pc_stall_o  out  1  hold PC.
- if_id_stall_o  out  1  hold IF/ID.
- id_ex_stall_o  out  1  hold ID/EX contents (MDU freeze).
- if_flush_o  out  1  zero IF/ID.
- id_flush_o  out  1  insert bubble into ID/EX.
- ex_flush_o  out  1  insert bubble into EX/MEM.
- stall_cnt_o  out  CNT_W  cycles with pc_stall_o high, saturating.
- flush_cnt_o  out  CNT_W  taken-branch flush events, saturating.

## Operation

- FSM states: IDLE, LOAD_WAIT, MDU_BUSY. A down-counter `rem` (width ≥ clog2(max(MEM_LAT, MDU_LAT))) tracks the remaining cycles.
- Load-use hit: `ex_memread_i && ex_rt_i != 0 && (ex_rt_i == id_rs_i || (id_uses_rt_i && ex_rt_i == id_rt_i))`. A destination of $0 never causes a hazard.
- Priority in IDLE: branch_taken_i, then mdu_start_i, then load-use hit.
- IDLE behaviour:
  - Branch: if_flush_o = id_flush_o = ex_flush_o = 1. Stay in IDLE. flush_cnt_o increments.
  - MDU start: pc_stall_o, if_id_stall_o, id_ex_stall_o and ex_flush_o are 1. If MDU_LAT > 1, go to MDU_BUSY with rem = MDU_LAT-2.
  - Load-use hit: pc_stall_o, if_id_stall_o and id_flush_o are 1. If MEM_LAT > 1, go to LOAD_WAIT with rem = MEM_LAT-2.
  - Otherwise all control outputs are 0.
- LOAD_WAIT: drives the load-use outputs unconditionally. When rem == 0, go to IDLE; otherwise decrement rem.
- MDU_BUSY: drives the MDU outputs unconditionally. When rem == 0, go to IDLE; otherwise decrement rem.
- branch_taken_i in LOAD_WAIT or MDU_BUSY:
  - This is illegal by pipeline construction.
  - Required behaviour: emit the branch flush outputs only, count the flush, return to IDLE.
- Counters:
  - stall_cnt_o increments in every cycle with pc_stall_o = 1. flush_cnt_o increments on every cycle a branch flush is emitted.
  - Both saturate at all-ones.
  - clr_cnt_i zeroes both counters and takes priority over an increment in the same cycle.

## Timing

- Control outputs are combinational from the state and the current inputs. There is zero-cycle latency from a hazard condition to its stall/flush.
- A load-use hit produces exactly MEM_LAT consecutive stall cycles.
- An MDU op produces exactly MDU_LAT consecutive freeze cycles, counting its start cycle.
- Back-to-back: a new hazard is evaluated in the first cycle after returning to IDLE. There is no dead cycle.
- Reset:
  - While rst_i is high, all control outputs are 0.
  - On the edge, state = IDLE, rem = 0 and both counters = 0.
  - Reset asserted mid-stall aborts the stall immediately.
- Counters update on the clock edge. The value is visible the cycle after the event.

## Test plan

- Load-use, MEM_LAT=1: ex_memread_i=1, ex_rt_i=8, id_rs_i=8 for one cycle -> pc_stall_o/if_id_stall_o/id_flush_o high for 1 cycle; stall_cnt_o = 1.
- Load-use, MEM_LAT=3: ex_rt_i=9, id_rt_i=9, id_uses_rt_i=1 for one cycle, then ex_memread_i=0 -> stall held for 3 cycles; stall_cnt_o = 3. Repeat with id_uses_rt_i=0 -> no stall.
- $0 filter: ex_memread_i=1, ex_rt_i=0, id_rs_i=0 -> all control outputs 0.
- MDU, MDU_LAT=4: mdu_start_i pulse -> pc/if_id/id_ex stall and ex_flush_o high for 4 cycles, then released; simultaneous load-use hit in the start cycle is ignored.
- Branch priority: branch_taken_i=1 together with a load-use hit -> only if/id/ex flush high; no stall; flush_cnt_o = 1. Branch injected in LOAD_WAIT -> flush emitted, FSM back to IDLE the next cycle.
- Reset and saturation:
  - rst_i asserted in cycle 2 of a 4-cycle MDU freeze -> outputs 0 immediately and IDLE after the edge.
  - With CNT_W=4, 20 stall cycles -> stall_cnt_o = 15.
  - clr_cnt_i -> 0.
